// File: rtl/enc_period_sched.sv
// Round-robin scheduler serializing per-channel encoder period words onto one req/ack write port.
// Optional write timeout/drop is enabled by defining ENC_PERIOD_SCHED_TIMEOUT_EN.
module enc_period_sched #(
    parameter int NUM_CH  = 4,
    parameter int DW      = 32,
    parameter int CW      = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk_fast,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    ch_valid,
    input  logic [NUM_CH*DW-1:0] ch_period,
    input  logic                 snap_req,
    input  logic                 overrun_clr,
    output logic                 wr_req,
    input  logic                 wr_ack,
    output logic [CW-1:0]        wr_chan,
    output logic [DW-1:0]        wr_data,
    output logic                 snap_done,
    output logic [NUM_CH-1:0]    overrun,
    output logic                 wr_drop
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [DW-1:0]     hold [NUM_CH];
    logic [NUM_CH-1:0] pending, pending_next, snap_mask, mask_after;
    logic [NUM_CH-1:0] grant_dec, done_dec, new_ovr;
    logic [CW-1:0]     last_grant, grant_idx, cand_idx;
    logic              grant_found, grant, ack_take, drop_take, snap_active;

`ifdef ENC_PERIOD_SCHED_TIMEOUT_EN
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);
    logic [3:0] wait_cnt;
`endif

    // First pending channel after last_grant, wrapping modulo NUM_CH.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand_idx = CW'((int'(last_grant) + k) % NUM_CH);
            if (!grant_found && pending[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign grant  = (state == IDLE) && grant_found;
    assign wr_req = (state == REQ);

    always_ff @(posedge clk_fast or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ack_take   = 1'b0;
        drop_take  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (wr_ack) begin
                    ack_take   = 1'b1;
                    state_next = IDLE;
                end
`ifdef ENC_PERIOD_SCHED_TIMEOUT_EN
                else if (wait_cnt == TO_LAST) begin
                    drop_take  = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // A channel granted this cycle is not an overrun even if it is re-strobed.
    always_comb begin
        grant_dec = '0;
        done_dec  = '0;
        if (grant) begin
            grant_dec[grant_idx] = 1'b1;
        end
        if (ack_take || drop_take) begin
            done_dec[wr_chan] = 1'b1;
        end
        new_ovr      = ch_valid & pending & ~grant_dec;
        pending_next = (pending & ~grant_dec) | ch_valid | {NUM_CH{snap_req}};
        mask_after   = snap_mask & ~done_dec;
    end

    always_ff @(posedge clk_fast or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hold[i] <= '0;
            end
            pending     <= '0;
            overrun     <= '0;
            last_grant  <= CW'(NUM_CH - 1);
            wr_chan     <= '0;
            wr_data     <= '0;
            snap_active <= 1'b0;
            snap_mask   <= '0;
            snap_done   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_valid[i]) begin
                    hold[i] <= ch_period[i*DW +: DW];
                end
            end
            pending <= pending_next;
            overrun <= (overrun & ~{NUM_CH{overrun_clr}}) | new_ovr;
            if (grant) begin
                wr_chan    <= grant_idx;
                wr_data    <= hold[grant_idx];
                last_grant <= grant_idx;
            end
            snap_done <= 1'b0;
            if (snap_req) begin
                snap_active <= 1'b1;
                snap_mask   <= '1;
            end else begin
                snap_mask <= mask_after;
                if (snap_active && (mask_after == '0)) begin
                    snap_done   <= 1'b1;
                    snap_active <= 1'b0;
                end
            end
        end
    end

`ifdef ENC_PERIOD_SCHED_TIMEOUT_EN
    always_ff @(posedge clk_fast or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            wr_drop  <= 1'b0;
        end else begin
            wr_drop  <= drop_take;
            wait_cnt <= ((state == REQ) && (state_next == REQ)) ? wait_cnt + 4'd1 : 4'd0;
        end
    end
`else
    assign wr_drop = 1'b0;
`endif

endmodule

// File: doc/enc_period_sched.md
Name: enc_period_sched

Overview:
- Round-robin scheduler that shares one register-file write port among NUM_CH encoder period channels.
- Each channel's quad period block issues a one-cycle update strobe with a 32-bit period word. The scheduler buffers the newest word per channel and serializes the buffered words onto a req/ack write port toward the host register file.
- It also supports a host-requested snapshot, which re-issues every channel, and keeps per-channel sticky overrun flags.

Parameters:
- NUM_CH, 4: number of encoder channels (2..8).
- DW, 32: period word width.
- CW, 2: channel index width; must satisfy 2^CW >= NUM_CH.
- TIMEOUT, 15: clk_fast cycles to wait for wr_ack before dropping a write (used only with the optional feature).

Ports:
- clk_fast, in, 1: fast measurement clock; all logic on its rising edge.
- reset, in, 1: asynchronous, active-low reset; clock is clk_fast.
- ch_valid, in, NUM_CH: one-cycle update strobe per channel.
- ch_period, in, NUM_CH*DW: period words; channel i occupies bits [i*DW +: DW].
- snap_req, in, 1: one-cycle host snapshot request.
- overrun_clr, in, 1: clears all overrun flags.
- wr_req, out, 1: write request to the register file.
- wr_ack, in, 1: write accepted.
- wr_chan, out, CW: channel index of the current write.
- wr_data, out, DW: period word of the current write.
- snap_done, out, 1: one-cycle pulse when a snapshot completes.
- overrun, out, NUM_CH: sticky flag; a pending word was overwritten before it was written.
- wr_drop, out, 1: one-cycle pulse when a write is abandoned on timeout.

Behaviour:
- Reset values:
  - All outputs are 0.
  - Holding registers and pending bits are 0.
  - Round-robin pointer last_grant = NUM_CH-1, so channel 0 has first priority.
  - snap_active and snap_mask are 0.
- Capture, per channel i, when ch_valid[i] = 1:
  - hold[i] <= ch_period[i]; pending[i] <= 1.
  - If pending[i] was already 1 and channel i is not being granted in the same cycle, set overrun[i]. The newest word wins.
- overrun_clr clears all overrun bits. If overrun_clr and a new overrun occur in the same cycle, the set wins.
- FSM, 2 states:
  - IDLE: if any pending bit is set, grant the first pending channel searching from last_grant+1 with wrap-around.
    - Load wr_chan and wr_data from that channel's holding register.
    - Clear its pending bit; update last_grant; go to REQ.
    - Grant latency: wr_req is high on the cycle after pending is first set.
  - REQ: wr_req = 1. wr_chan and wr_data are stable until ack.
    - On wr_ack = 1, go to IDLE. The next grant happens 1 cycle later, so back-to-back writes occur at most every 2 cycles.
- Grant collision: ch_valid[i] in the same cycle channel i is granted sends the old hold[i] to wr_data. The new word is captured with pending[i] = 1 and no overrun.
- wr_ack while in IDLE is ignored.
- Snapshot:
  - snap_req sets pending on all channels and sets snap_active; snap_mask <= all ones. No overrun is flagged.
  - Each acked (or dropped) write of channel i clears snap_mask[i].
  - When snap_mask reaches 0 with snap_active = 1: pulse snap_done for 1 cycle and clear snap_active.
  - snap_req while snap_active = 1 re-arms snap_mask to all ones; no extra snap_done is produced.
  - Before any ch_valid, a snapshot writes zeros.
- Reset mid-transaction: wr_req drops asynchronously and nothing is retained.
- Widths: hold is DW bits; the search uses modulo-NUM_CH arithmetic; indices >= NUM_CH are never granted.

Optional Feature:
- ENC_PERIOD_SCHED_TIMEOUT_EN defined:
  - A 4-bit wait counter runs while in REQ.
  - If TIMEOUT cycles elapse without wr_ack: pulse wr_drop, deassert wr_req, return to IDLE. The word is discarded and pending is not restored.
  - wr_ack on the same cycle as timeout expiry counts as ack, and no drop occurs.
- Undefined: REQ waits indefinitely and wr_drop is tied to 0.

Test Plan:
- Reset, then ch_valid[2] with ch_period[2] = 32'h8000_1234 and wr_ack given 3 cycles after wr_req -> one write with wr_chan = 2 and wr_data = 32'h8000_1234; wr_req high for 4 cycles; overrun = 0.
- ch_valid on all 4 channels in the same cycle with immediate ack -> writes in order 0, 1, 2, 3 at 2-cycle spacing. Then ch_valid[0] and ch_valid[3] together -> order 0, then 3, with wraparound from last_grant = 3.
- Hold wr_ack low and pulse ch_valid[1] twice with values 5 then 9 -> overrun[1] = 1; the subsequent write carries 9. overrun_clr returns overrun to 0.
- Write of channel 1 in REQ while ch_valid[1] carries new value 7 in the grant cycle -> the current write keeps the old value; a second write carries 7; overrun[1] = 0.
- snap_req after all channels are loaded, with immediate acks -> 4 writes; snap_done pulses once, 1 cycle after the last ack.
- With ENC_PERIOD_SCHED_TIMEOUT_EN and TIMEOUT = 15, wr_ack never asserted -> wr_drop pulses 15 cycles after wr_req rises; wr_req = 0 and the FSM returns to IDLE. Assert reset mid-REQ -> all outputs go to 0 asynchronously.
